// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-output bundle for serial_bit_feeder.
// master = word source / serial consumer side, slave = the feeder itself.
interface serial_bit_feeder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              pause;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_done;
    logic              busy;

    modport master (
        output s_data, s_valid, pause,
        input  s_ready, ser_out, ser_valid, frame_done, busy
    );

    modport slave (
        input  s_data, s_valid, pause,
        output s_ready, ser_out, ser_valid, frame_done, busy
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one word per valid/ready accept, one bit per clk on ser_out.
// Define PARITY_EN to append an even-parity bit after the data bits of every frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; ser_out idles, s_ready high unless paused
// S_SHIFT | frame in progress; r_bit_cnt is the index of the bit on ser_out
module serial_bit_feeder #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    serial_bit_feeder_if.slave  bus
);

`ifdef PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif
    localparam int              CNT_W    = $clog2(FL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FL - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_ser_out;
    logic              r_ser_valid;
    logic              r_frame_done;
`ifdef PARITY_EN
    logic              r_parity;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`endif

    logic              w_at_last;
    logic              w_ready;
    logic              w_accept;
    logic              w_advance;
    logic              w_first_bit;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shreg_next;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_at_last = (r_state == S_SHIFT) && (r_bit_cnt == LAST_CNT);
    assign w_ready   = !reset && !bus.pause && ((r_state == S_IDLE) || w_at_last);
    assign w_accept  = bus.s_valid && w_ready;
    assign w_advance = (r_state == S_SHIFT) && !bus.pause && !w_at_last;
    assign w_cnt_inc = r_bit_cnt + CNT_W'(1);

    assign w_first_bit = MSB_FIRST ? bus.s_data[DATA_W-1] : bus.s_data[0];

    // r_shreg head always holds the bit currently on ser_out
    always_comb begin
        w_shreg_next = MSB_FIRST ? {r_shreg[DATA_W-2:0], 1'b0} : {1'b0, r_shreg[DATA_W-1:1]};
        w_next_bit   = MSB_FIRST ? r_shreg[DATA_W-2] : r_shreg[1];
`ifdef PARITY_EN
        if (r_bit_cnt == DATA_LAST) begin
            w_next_bit = r_parity;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state      <= S_SHIFT;
            r_bit_cnt    <= '0;
            r_shreg      <= bus.s_data;
            r_ser_out    <= w_first_bit;
            r_ser_valid  <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef PARITY_EN
            r_parity     <= ^bus.s_data;
`endif
        end else if (w_advance) begin
            r_bit_cnt    <= w_cnt_inc;
            r_shreg      <= w_shreg_next;
            r_ser_out    <= w_next_bit;
            r_ser_valid  <= 1'b1;
            r_frame_done <= (w_cnt_inc == LAST_CNT);
        end else begin
            // paused (hold position) or last bit done with no follow-on word
            if ((r_state == S_SHIFT) && !bus.pause) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
            end
            r_ser_out    <= IDLE_BIT;
            r_ser_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.ser_out    = r_ser_out;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: MSB-first main instance plus an LSB-first instance.
// Build with +define+PARITY_EN to cover the parity frame format.
module tb_serial_bit_feeder;

`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk;
    logic reset;

    serial_bit_feeder_if #(.DATA_W(8)) bus ();
    serial_bit_feeder_if #(.DATA_W(8)) b1 ();

    serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_bits = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: {bit, last_of_frame}
    logic [1:0] q[$];
    logic       m_valid = 1'b0;
    logic       m_inframe = 1'b0;

    function automatic void push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q.push_back({w[7-i], (i == 7) && !PAR});
        if (PAR) q.push_back({^w, 1'b1});
    endfunction

    always @(negedge clk) begin
        logic [1:0] e;
        if (reset) begin
            chk("rst_ser_valid", bus.ser_valid, 0);
            chk("rst_ser_out", bus.ser_out, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_s_ready", bus.s_ready, 0);
            q.delete();
            m_valid   = 1'b0;
            m_inframe = 1'b0;
        end else begin
            chk("ser_valid", bus.ser_valid, m_valid);
            chk("busy", bus.busy, m_inframe);
            if (m_valid) begin
                n_valid_bits++;
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ser_out", bus.ser_out, e[1]);
                    chk("frame_done", bus.frame_done, e[0]);
                end
            end else begin
                chk("idle_ser_out", bus.ser_out, 1);
                chk("idle_frame_done", bus.frame_done, 0);
            end
            chk("s_ready", bus.s_ready, !bus.pause && (q.size() == 0));
            if (bus.pause) begin
                m_valid = 1'b0;
            end else if (bus.s_valid && q.size() == 0) begin
                push_word(bus.s_data);
                m_valid   = 1'b1;
                m_inframe = 1'b1;
            end else if (q.size() > 0) begin
                m_valid = 1'b1;
            end else begin
                m_valid   = 1'b0;
                m_inframe = 1'b0;
            end
        end
    end

    // present a word; returns at posedge+2 after it has been accepted
    task automatic send(input logic [7:0] w, input bit keep_valid);
        bit ok = 1'b0;
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (bus.s_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #2;
        if (!keep_valid) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !m_inframe) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    initial begin
        int vb0;
        logic [7:0] lsb_w;
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int vb0;
        logic [7:0] lsb_w;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.pause   = 1'b0;
        b1.s_valid  = 1'b0;
        b1.s_data   = 8'h00;
        b1.pause    = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2;

        // single word
        vb0 = n_valid_bits;
        send(8'h24, 1'b0);
        drain();
        chk("single_bits", n_valid_bits - vb0, PAR ? 9 : 8);

        // back-to-back words with s_valid held
        vb0 = n_valid_bits;
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b0);
        drain();
        chk("b2b_bits", n_valid_bits - vb0, PAR ? 18 : 16);

        // pause mid-frame
        vb0 = n_valid_bits;
        send(8'h24, 1'b0);
        repeat (2) @(posedge clk);
        #2 bus.pause = 1'b1;
        repeat (3) @(posedge clk);
        #2 bus.pause = 1'b0;
        drain();
        chk("pause_bits", n_valid_bits - vb0, PAR ? 9 : 8);

        // pause across a back-to-back boundary
        send(8'h81, 1'b1);
        repeat (6) @(posedge clk);
        #2 bus.pause = 1'b1;
        repeat (4) @(posedge clk);
        #2 bus.pause = 1'b0;
        send(8'h7E, 1'b0);
        drain();

        // reset mid-frame, then a fresh word
        send(8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ser_out", bus.ser_out, 1);
        chk("mid_rst_ser_valid", bus.ser_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2;
        send(8'h0F, 1'b0);
        drain();

`ifdef PARITY_EN
        send(8'h07, 1'b1);
        send(8'h03, 1'b0);
        drain();
`endif

        // LSB-first instance, word 0x01
        lsb_w = 8'h01;
        b1.s_data  = lsb_w;
        b1.s_valid = 1'b1;
        #1 chk("lsb_s_ready", b1.s_ready, 1);
        @(posedge clk); #2;
        b1.s_valid = 1'b0;
        b1.s_data  = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_valid", b1.ser_valid, 1);
            chk("lsb_bit", b1.ser_out, lsb_w[i]);
        end
        if (PAR) begin
            @(negedge clk);
            chk("lsb_parity", b1.ser_out, 1);
        end
        @(negedge clk);
        chk("lsb_end_valid", b1.ser_valid, 0);
        chk("lsb_end_out", b1.ser_out, 1);
        @(posedge clk); #2;

        // random traffic with pauses
        for (int c = 0; c < 400; c++) begin
            bus.s_valid = ($urandom_range(0, 2) != 0);
            bus.s_data  = 8'($urandom);
            bus.pause   = ($urandom_range(0, 5) == 0);
            @(posedge clk); #2;
        end
        bus.s_valid = 1'b0;
        bus.pause   = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
